// File: rtl/ifm_fifo_rd_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : ifm_fifo_rd_ctrl
// Purpose  : skewed per-lane read sequencer for the ping-pong IFM FIFO banks
// Revision : 1.0
// ==========================================================================
module ifm_fifo_rd_ctrl #(
    parameter int NUM_FIFO  = 16,
    parameter int CNT_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] rd_len,
    input  logic [4:0]           num_lane,
    input  logic                 bank_sel,
    output logic [NUM_FIFO-1:0]  rd_en_1,
    output logic [NUM_FIFO-1:0]  rd_en_2,
    output logic                 rd_clr_1,
    output logic                 rd_clr_2,
    output logic                 ifm_mux,
    output logic                 busy,
    output logic                 done
);

    typedef logic [NUM_FIFO-1:0] lane_t;
    typedef logic [CNT_WIDTH:0]  cnt_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [5:0] c_max_lanes = (NUM_FIFO < 16) ? 6'(NUM_FIFO) : 6'd16;

    state_t     state_q;
    cnt_t       cnt_q;
    logic [5:0] nlane_q;
    lane_t      mask_q;
    lane_t      chain_q;
    lane_t      rd_en_1_q;
    lane_t      rd_en_2_q;
    logic       clr_1_q;
    logic       clr_2_q;
    logic       bank_q;
    logic       busy_q;
    logic       done_q;

    logic [5:0] nlane_d;
    cnt_t       len_d;
    lane_t      mask_d;
    lane_t      chain_d;

    // cnt_q holds the RUN cycles still to go; lane 0 stays on while more than
    // nlane_q remain, the tail being the skew drain of the upper lanes.
    always_comb begin
        nlane_d = (num_lane == 5'd0 || num_lane > 5'd16) ? 6'd16 : {1'b0, num_lane};
        if (nlane_d > c_max_lanes) begin
            nlane_d = c_max_lanes;
        end
        len_d  = (rd_len == '0) ? cnt_t'(1) : cnt_t'(rd_len);
        mask_d = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            mask_d[i] = (i < int'(nlane_d));
        end
        chain_d = (chain_q << 1) | lane_t'(cnt_q > cnt_t'(nlane_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            nlane_q   <= '0;
            mask_q    <= '0;
            chain_q   <= '0;
            rd_en_1_q <= '0;
            rd_en_2_q <= '0;
            clr_1_q   <= 1'b0;
            clr_2_q   <= 1'b0;
            bank_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            clr_1_q <= 1'b0;
            clr_2_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    chain_q   <= '0;
                    rd_en_1_q <= '0;
                    rd_en_2_q <= '0;
                    if (start) begin
                        state_q   <= S_RUN;
                        cnt_q     <= len_d + cnt_t'(nlane_d) - cnt_t'(1);
                        nlane_q   <= nlane_d;
                        mask_q    <= mask_d;
                        bank_q    <= bank_sel;
                        busy_q    <= 1'b1;
                        chain_q   <= lane_t'(1);
                        rd_en_1_q <= bank_sel ? '0 : lane_t'(1);
                        rd_en_2_q <= bank_sel ? lane_t'(1) : '0;
                    end
                end
                S_RUN: begin
                    if (cnt_q == cnt_t'(1)) begin
                        state_q   <= S_CLEAR;
                        chain_q   <= '0;
                        rd_en_1_q <= '0;
                        rd_en_2_q <= '0;
                        clr_1_q   <= ~bank_q;
                        clr_2_q   <= bank_q;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q - cnt_t'(1);
                        chain_q   <= chain_d;
                        rd_en_1_q <= bank_q ? '0 : (chain_d & mask_q);
                        rd_en_2_q <= bank_q ? (chain_d & mask_q) : '0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en_1  = rd_en_1_q;
    assign rd_en_2  = rd_en_2_q;
    assign rd_clr_1 = clr_1_q;
    assign rd_clr_2 = clr_2_q;
    assign ifm_mux  = bank_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ifm_fifo_rd_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : tb_ifm_fifo_rd_ctrl
// Purpose  : cycle-accurate scoreboard bench for ifm_fifo_rd_ctrl
// Revision : 1.0
// ==========================================================================
module tb_ifm_fifo_rd_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [12:0] rd_len;
    logic [4:0]  num_lane;
    logic        bank_sel;
    logic [15:0] rd_en_1;
    logic [15:0] rd_en_2;
    logic        rd_clr_1;
    logic        rd_clr_2;
    logic        ifm_mux;
    logic        busy;
    logic        done;

    ifm_fifo_rd_ctrl #(.NUM_FIFO(16), .CNT_WIDTH(13)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_len   (rd_len),
        .num_lane (num_lane),
        .bank_sel (bank_sel),
        .rd_en_1  (rd_en_1),
        .rd_en_2  (rd_en_2),
        .rd_clr_1 (rd_clr_1),
        .rd_clr_2 (rd_clr_2),
        .ifm_mux  (ifm_mux),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] e1;
        logic [15:0] e2;
        logic        c1;
        logic        c2;
        logic        mux;
        logic        bsy;
        logic        dn;
    } obs_t;

    typedef struct {
        logic [12:0] len;
        logic [4:0]  nl;
        logic        bank;
        int          exp_dur;
        int          exp_sum;
    } burst_t;

    obs_t   exp_q[$];
    obs_t   got;
    logic   mux_m;
    int     n_cmp;
    int     n_bad;
    int     cyc;
    burst_t tbl[7];

    // Expected per-cycle outputs of an accepted burst, from its timing rules.
    task automatic push_burst(input logic [12:0] len, input logic [4:0] nl, input logic bs);
        int le;
        int ne;
        obs_t e;
        le = (len == 13'd0) ? 1 : int'(len);
        ne = (nl == 5'd0 || nl > 5'd16) ? 16 : int'(nl);
        mux_m = bs;
        for (int k = 1; k <= le + ne; k++) begin
            e = '0;
            for (int i = 0; i < ne; i++) begin
                if (k >= 1 + i && k <= le + i) begin
                    if (bs) e.e2[i] = 1'b1;
                    else    e.e1[i] = 1'b1;
                end
            end
            e.bsy = 1'b1;
            e.mux = bs;
            if (k == le + ne) begin
                e.dn = 1'b1;
                e.c1 = ~bs;
                e.c2 = bs;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input logic st, input logic [12:0] len, input logic [4:0] nl,
                        input logic bs, input logic rs);
        obs_t cur;
        start    = st;
        rd_len   = len;
        num_lane = nl;
        bank_sel = bs;
        reset    = rs;
        @(negedge clk);
        got = {rd_en_1, rd_en_2, rd_clr_1, rd_clr_2, ifm_mux, busy, done};
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = '0;
            cur.mux = mux_m;
        end
        n_cmp++;
        if (got !== cur) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: got %h expected %h", cyc, got, cur);
        end
        if (rs) begin
            exp_q.delete();
            mux_m = 1'b0;
        end else if (st && !cur.bsy) begin
            push_burst(len, nl, bs);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_burst(input burst_t b, input int inj_at);
        int  dur;
        int  sum;
        bit  seen;
        step(1'b1, b.len, b.nl, b.bank, 1'b0);
        dur  = 0;
        sum  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            if (k == inj_at) step(1'b1, 13'd7, 5'd5, ~b.bank, 1'b0);
            else             step(1'b0, b.len, b.nl, b.bank, 1'b0);
            sum += b.bank ? $countones(got.e2) : $countones(got.e1);
            if (got.dn) begin
                seen = 1'b1;
                dur  = k;
            end
        end
        n_cmp++;
        if (!seen || dur != b.exp_dur) begin
            n_bad++;
            $display("FAIL burst_len len=%0d nl=%0d: got %0d required %0d", b.len, b.nl, dur, b.exp_dur);
        end
        n_cmp++;
        if (sum != b.exp_sum) begin
            n_bad++;
            $display("FAIL enable_total len=%0d nl=%0d: got %0d required %0d", b.len, b.nl, sum, b.exp_sum);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        mux_m = 1'b0;
        tbl[0] = '{13'd4, 5'd3,  1'b0, 7,  12};
        tbl[1] = '{13'd9, 5'd16, 1'b1, 25, 144};
        tbl[2] = '{13'd0, 5'd16, 1'b0, 17, 16};
        tbl[3] = '{13'd5, 5'd0,  1'b1, 21, 80};
        tbl[4] = '{13'd3, 5'd20, 1'b0, 19, 48};
        tbl[5] = '{13'd2, 5'd5,  1'b1, 7,  10};
        tbl[6] = '{13'd1, 5'd1,  1'b0, 2,  1};

        start    = 1'b0;
        rd_len   = '0;
        num_lane = '0;
        bank_sel = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 13'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 13'd0, 5'd0, 1'b0, 1'b0);

        // Table bursts back to back, banks alternating.
        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i], 0);
        end

        // A start arriving mid-burst must be dropped, then idle must follow.
        repeat (2) step(1'b0, 13'd0, 5'd0, 1'b0, 1'b0);
        run_burst(tbl[0], 3);
        repeat (4) step(1'b0, 13'd0, 5'd0, 1'b0, 1'b0);
        run_burst(tbl[5], 0);

        // Reset in the middle of a long burst.
        step(1'b1, 13'd20, 5'd8, 1'b1, 1'b0);
        repeat (4) step(1'b0, 13'd20, 5'd8, 1'b1, 1'b0);
        step(1'b0, 13'd20, 5'd8, 1'b1, 1'b1);
        repeat (4) step(1'b0, 13'd20, 5'd8, 1'b1, 1'b0);
        run_burst(tbl[1], 0);
        repeat (3) step(1'b0, 13'd0, 5'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
